// File: rtl/regfile_writeback_if.sv
// Bundle of the completion, issue, scoreboard-query and RAM-write signals
// around the register-file write-back arbiter.
interface regfile_writeback_if;
   logic        alu_valid;
   logic [4:0]  alu_dest;
   logic [31:0] alu_data;

   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_dest;
   logic [31:0] mem_data;

   logic        div_valid;
   logic        div_ready;
   logic [4:0]  div_dest;
   logic [31:0] div_data;

   logic        issue_valid;
   logic [4:0]  issue_dest;

   logic [4:0]  q_addr_a;
   logic [4:0]  q_addr_b;
   logic        q_busy_a;
   logic        q_busy_b;

   logic        rf_wren;
   logic [4:0]  rf_wraddress;
   logic [31:0] rf_data;

   // Arbiter side
   modport slave (
      input  alu_valid, alu_dest, alu_data,
      input  mem_valid, mem_dest, mem_data,
      output mem_ready,
      input  div_valid, div_dest, div_data,
      output div_ready,
      input  issue_valid, issue_dest,
      input  q_addr_a, q_addr_b,
      output q_busy_a, q_busy_b,
      output rf_wren, rf_wraddress, rf_data
   );

   // Execute/decode side
   modport master (
      output alu_valid, alu_dest, alu_data,
      output mem_valid, mem_dest, mem_data,
      input  mem_ready,
      output div_valid, div_dest, div_data,
      input  div_ready,
      output issue_valid, issue_dest,
      output q_addr_a, q_addr_b,
      input  q_busy_a, q_busy_b,
      input  rf_wren, rf_wraddress, rf_data
   );
endinterface

// File: rtl/regfile_writeback.sv
// Single-write-port arbiter and pending-register scoreboard in front of the
// 32x32 register-file RAM. ALU completions have strict priority; the load/store
// and divider results wait in one-entry holding buffers and share the port
// round-robin when both are waiting. Register 0 is never written.
module regfile_writeback #(
   parameter int NREG = 32   // at most 32: destinations are 5-bit
) (
   input  logic              clock,
   input  logic              reset_n,
   regfile_writeback_if.slave bus
);

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MEM  = 2'd2,
      SRC_DIV  = 2'd3
   } src_t;

   // Holding buffers
   logic            mem_full_r;
   logic [4:0]      mem_dest_r;
   logic [31:0]     mem_data_r;
   logic            div_full_r;
   logic [4:0]      div_dest_r;
   logic [31:0]     div_data_r;

   // Arbitration
   logic            rr_r;
   logic            both_full_s;
   src_t            grant_s;
   logic [4:0]      win_dest_s;
   logic [31:0]     win_data_s;

   // Output register; wr_slow_r marks an entry that came from mem/div
   logic            rf_wren_r;
   logic [4:0]      rf_wraddress_r;
   logic [31:0]     rf_data_r;
   logic            wr_slow_r;

   // Scoreboard
   logic [NREG-1:0] pending_r;
   logic [NREG-1:0] pending_nxt_s;
   logic            q_busy_a_s;
   logic            q_busy_b_s;

   // Pick at most one winner: ALU first, then whichever buffer is full, rr on a tie
   always_comb begin
      grant_s     = SRC_NONE;
      both_full_s = mem_full_r && div_full_r;
      if (bus.alu_valid) begin
         grant_s = SRC_ALU;
      end else if (both_full_s) begin
         grant_s = rr_r ? SRC_DIV : SRC_MEM;
      end else if (mem_full_r) begin
         grant_s = SRC_MEM;
      end else if (div_full_r) begin
         grant_s = SRC_DIV;
      end else begin
         grant_s = SRC_NONE;
      end
   end

   // Route the winner's destination and data toward the output register
   always_comb begin
      win_dest_s = 5'd0;
      win_data_s = 32'd0;
      case (grant_s)
         SRC_ALU: begin
            win_dest_s = bus.alu_dest;
            win_data_s = bus.alu_data;
         end
         SRC_MEM: begin
            win_dest_s = mem_dest_r;
            win_data_s = mem_data_r;
         end
         SRC_DIV: begin
            win_dest_s = div_dest_r;
            win_data_s = div_data_r;
         end
         default: begin
            win_dest_s = 5'd0;
            win_data_s = 32'd0;
         end
      endcase
   end

   // mem buffer: empties when granted, loads on a handshake while empty
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_full_r <= 1'b0;
         mem_dest_r <= 5'd0;
         mem_data_r <= 32'd0;
      end else if (grant_s == SRC_MEM) begin
         mem_full_r <= 1'b0;
      end else if (bus.mem_valid && !mem_full_r) begin
         mem_full_r <= 1'b1;
         mem_dest_r <= bus.mem_dest;
         mem_data_r <= bus.mem_data;
      end else begin
         mem_full_r <= mem_full_r;
      end
   end

   // div buffer: empties when granted, loads on a handshake while empty
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_full_r <= 1'b0;
         div_dest_r <= 5'd0;
         div_data_r <= 32'd0;
      end else if (grant_s == SRC_DIV) begin
         div_full_r <= 1'b0;
      end else if (bus.div_valid && !div_full_r) begin
         div_full_r <= 1'b1;
         div_dest_r <= bus.div_dest;
         div_data_r <= bus.div_data;
      end else begin
         div_full_r <= div_full_r;
      end
   end

   // Round-robin bit flips only when a buffer wins a tie between both buffers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_r <= 1'b0;
      end else if (both_full_s && (grant_s != SRC_ALU)) begin
         rr_r <= !rr_r;
      end else begin
         rr_r <= rr_r;
      end
   end

   // RAM write port register; address/data hold when nothing is granted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_wren_r      <= 1'b0;
         rf_wraddress_r <= 5'd0;
         rf_data_r      <= 32'd0;
         wr_slow_r      <= 1'b0;
      end else if (grant_s != SRC_NONE) begin
         rf_wren_r      <= (win_dest_s != 5'd0);
         rf_wraddress_r <= win_dest_s;
         rf_data_r      <= win_data_s;
         wr_slow_r      <= (grant_s != SRC_ALU);
      end else begin
         rf_wren_r      <= 1'b0;
         wr_slow_r      <= 1'b0;
      end
   end

   // Next scoreboard: clear on a slow-unit RAM write, set on issue; set wins, r0 stays 0
   always_comb begin
      pending_nxt_s    = {NREG{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         pending_nxt_s[i] =
            (bus.issue_valid && (bus.issue_dest == 5'(i))) ? 1'b1 :
            (rf_wren_r && wr_slow_r && (rf_wraddress_r == 5'(i))) ? 1'b0 :
            pending_r[i];
      end
   end

   // Scoreboard state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_r <= {NREG{1'b0}};
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   // Combinational hazard queries; address 0 never matches so it reads 0
   always_comb begin
      q_busy_a_s = 1'b0;
      q_busy_b_s = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         q_busy_a_s = q_busy_a_s | (pending_r[i] & (bus.q_addr_a == 5'(i)));
         q_busy_b_s = q_busy_b_s | (pending_r[i] & (bus.q_addr_b == 5'(i)));
      end
   end

   assign bus.mem_ready    = !mem_full_r;
   assign bus.div_ready    = !div_full_r;
   assign bus.q_busy_a     = q_busy_a_s;
   assign bus.q_busy_b     = q_busy_b_s;
   assign bus.rf_wren      = rf_wren_r;
   assign bus.rf_wraddress = rf_wraddress_r;
   assign bus.rf_data      = rf_data_r;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (queues for the holding buffers, a bit array for
// the scoreboard).
module tb_regfile_writeback;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   regfile_writeback_if bus ();

   regfile_writeback #(.NREG(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;
   bit cmp_on = 1'b0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  dest;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   ent_t        dq[$];
   bit          m_rr;
   bit [31:0]   m_pend;
   bit          m_wren;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_slow;

   task automatic model_reset();
      mq.delete();
      dq.delete();
      m_rr   = 1'b0;
      m_pend = 32'd0;
      m_wren = 1'b0;
      m_addr = 5'd0;
      m_data = 32'd0;
      m_slow = 1'b0;
   endtask

   // One clock edge worth of behaviour, from the inputs present before the edge
   task automatic model_step();
      ent_t w;
      bit   have;
      bit   slow;
      bit   macc;
      bit   dacc;
      have = 1'b0;
      slow = 1'b0;
      w.dest = 5'd0;
      w.data = 32'd0;
      macc = bus.mem_valid && (mq.size() == 0);
      dacc = bus.div_valid && (dq.size() == 0);
      if (bus.alu_valid) begin
         w.dest = bus.alu_dest;
         w.data = bus.alu_data;
         have = 1'b1;
      end else if (mq.size() > 0 && dq.size() > 0) begin
         if (m_rr) w = dq.pop_front();
         else      w = mq.pop_front();
         m_rr = !m_rr;
         have = 1'b1;
         slow = 1'b1;
      end else if (mq.size() > 0) begin
         w = mq.pop_front();
         have = 1'b1;
         slow = 1'b1;
      end else if (dq.size() > 0) begin
         w = dq.pop_front();
         have = 1'b1;
         slow = 1'b1;
      end
      if (m_wren && m_slow) m_pend[m_addr] = 1'b0;
      if (bus.issue_valid && bus.issue_dest != 5'd0) m_pend[bus.issue_dest] = 1'b1;
      if (have) begin
         m_wren = (w.dest != 5'd0);
         m_addr = w.dest;
         m_data = w.data;
         m_slow = slow;
      end else begin
         m_wren = 1'b0;
         m_slow = 1'b0;
      end
      if (macc) begin
         w.dest = bus.mem_dest;
         w.data = bus.mem_data;
         mq.push_back(w);
      end
      if (dacc) begin
         w.dest = bus.div_dest;
         w.data = bus.div_data;
         dq.push_back(w);
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock: the model sees the same pre-edge inputs as the DUT
   task automatic step();
      @(posedge clock);
      if (!reset_n) model_reset();
      else          model_step();
      #1;
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_dest = 5'd0; bus.alu_data = 32'd0;
      bus.mem_valid = 1'b0; bus.mem_dest = 5'd0; bus.mem_data = 32'd0;
      bus.div_valid = 1'b0; bus.div_dest = 5'd0; bus.div_data = 32'd0;
      bus.issue_valid = 1'b0; bus.issue_dest = 5'd0;
   endtask

   task automatic randomize_inputs();
      bus.alu_valid   = ($urandom_range(0, 3) == 0);
      bus.alu_dest    = 5'($urandom_range(0, 31));
      bus.alu_data    = $urandom;
      bus.mem_valid   = ($urandom_range(0, 1) == 1);
      bus.mem_dest    = 5'($urandom_range(0, 31));
      bus.mem_data    = $urandom;
      bus.div_valid   = ($urandom_range(0, 2) == 0);
      bus.div_dest    = 5'($urandom_range(0, 31));
      bus.div_data    = $urandom;
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_dest  = 5'($urandom_range(0, 31));
      bus.q_addr_a    = 5'($urandom_range(0, 31));
      bus.q_addr_b    = 5'($urandom_range(0, 31));
   endtask

   // Compare every output against the model, mid-cycle
   always @(negedge clock) begin
      if (cmp_on) begin
         chk("m_wren",   {31'd0, bus.rf_wren},   {31'd0, m_wren});
         chk("m_waddr",  {27'd0, bus.rf_wraddress}, {27'd0, m_addr});
         chk("m_wdata",  bus.rf_data, m_data);
         chk("m_mready", {31'd0, bus.mem_ready}, {31'd0, (mq.size() == 0)});
         chk("m_dready", {31'd0, bus.div_ready}, {31'd0, (dq.size() == 0)});
         chk("m_busy_a", {31'd0, bus.q_busy_a},  {31'd0, m_pend[bus.q_addr_a]});
         chk("m_busy_b", {31'd0, bus.q_busy_b},  {31'd0, m_pend[bus.q_addr_b]});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle();
      bus.q_addr_a = 5'd7;
      bus.q_addr_b = 5'd9;
      reset_n = 1'b0;
      model_reset();
      cmp_on = 1'b1;
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // reset state
      chk("rst_wren",   {31'd0, bus.rf_wren}, 32'd0);
      chk("rst_waddr",  {27'd0, bus.rf_wraddress}, 32'd0);
      chk("rst_wdata",  bus.rf_data, 32'd0);
      chk("rst_mready", {31'd0, bus.mem_ready}, 32'd1);
      chk("rst_dready", {31'd0, bus.div_ready}, 32'd1);
      chk("rst_busy_a", {31'd0, bus.q_busy_a}, 32'd0);

      // ALU write, then an ALU write to r0
      bus.alu_valid = 1'b1; bus.alu_dest = 5'd5; bus.alu_data = 32'h1234_5678;
      step();
      chk("alu_wren",  {31'd0, bus.rf_wren}, 32'd1);
      chk("alu_waddr", {27'd0, bus.rf_wraddress}, 32'd5);
      chk("alu_wdata", bus.rf_data, 32'h1234_5678);
      bus.alu_dest = 5'd0; bus.alu_data = 32'hDEAD_BEEF;
      step();
      chk("alu_r0_wren", {31'd0, bus.rf_wren}, 32'd0);
      idle();
      step();

      // scoreboard round trip on r7 (t = now)
      bus.issue_valid = 1'b1; bus.issue_dest = 5'd7;
      step();                                   // t+1
      chk("sb_busy_t1", {31'd0, bus.q_busy_a}, 32'd1);
      bus.issue_valid = 1'b0;
      step();                                   // t+2
      step();                                   // t+3
      bus.mem_valid = 1'b1; bus.mem_dest = 5'd7; bus.mem_data = 32'hCAFE_0001;
      step();                                   // t+4
      bus.mem_valid = 1'b0;
      chk("sb_mready_t4", {31'd0, bus.mem_ready}, 32'd0);
      chk("sb_busy_t4",   {31'd0, bus.q_busy_a}, 32'd1);
      step();                                   // t+5
      chk("sb_wren_t5",  {31'd0, bus.rf_wren}, 32'd1);
      chk("sb_waddr_t5", {27'd0, bus.rf_wraddress}, 32'd7);
      chk("sb_wdata_t5", bus.rf_data, 32'hCAFE_0001);
      chk("sb_busy_t5",  {31'd0, bus.q_busy_a}, 32'd1);
      step();                                   // t+6
      chk("sb_busy_t6",  {31'd0, bus.q_busy_a}, 32'd0);

      // ALU priority while the mem buffer is full
      bus.mem_valid = 1'b1; bus.mem_dest = 5'd11; bus.mem_data = 32'h1111_0011;
      step();
      bus.mem_valid = 1'b0;
      bus.alu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.alu_dest = 5'(20 + i);
         bus.alu_data = 32'hA0 + 32'(i);
         step();
         chk("pri_alu_waddr", {27'd0, bus.rf_wraddress}, 32'(20 + i));
         chk("pri_alu_wdata", bus.rf_data, 32'hA0 + 32'(i));
         chk("pri_mready",    {31'd0, bus.mem_ready}, 32'd0);
      end
      bus.alu_valid = 1'b0;
      step();
      chk("pri_mem_wren",  {31'd0, bus.rf_wren}, 32'd1);
      chk("pri_mem_waddr", {27'd0, bus.rf_wraddress}, 32'd11);
      chk("pri_mem_wdata", bus.rf_data, 32'h1111_0011);
      chk("pri_mready_after", {31'd0, bus.mem_ready}, 32'd1);

      // round-robin across four both-full ties: mem, div, mem, div first
      for (int k = 0; k < 4; k++) begin
         bus.mem_valid = 1'b1; bus.mem_dest = 5'(3 + k);  bus.mem_data = 32'h30 + 32'(k);
         bus.div_valid = 1'b1; bus.div_dest = 5'(16 + k); bus.div_data = 32'h60 + 32'(k);
         step();
         bus.mem_valid = 1'b0; bus.div_valid = 1'b0;
         step();
         chk("rr_first",  {27'd0, bus.rf_wraddress}, (k % 2 == 0) ? 32'(3 + k) : 32'(16 + k));
         step();
         chk("rr_second", {27'd0, bus.rf_wraddress}, (k % 2 == 0) ? 32'(16 + k) : 32'(3 + k));
      end

      // set/clear collision on r9
      bus.issue_valid = 1'b1; bus.issue_dest = 5'd9;
      step();
      bus.issue_valid = 1'b0;
      bus.div_valid = 1'b1; bus.div_dest = 5'd9; bus.div_data = 32'h0000_0099;
      step();
      bus.div_valid = 1'b0;
      step();
      chk("col_wren",  {31'd0, bus.rf_wren}, 32'd1);
      chk("col_waddr", {27'd0, bus.rf_wraddress}, 32'd9);
      bus.issue_valid = 1'b1; bus.issue_dest = 5'd9;
      step();
      bus.issue_valid = 1'b0;
      chk("col_busy_b", {31'd0, bus.q_busy_b}, 32'd1);
      step();
      chk("col_busy_b_hold", {31'd0, bus.q_busy_b}, 32'd1);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         randomize_inputs();
         step();
      end

      // reset in the middle of traffic
      randomize_inputs();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_wren",   {31'd0, bus.rf_wren}, 32'd0);
      chk("mid_rst_waddr",  {27'd0, bus.rf_wraddress}, 32'd0);
      chk("mid_rst_wdata",  bus.rf_data, 32'd0);
      chk("mid_rst_mready", {31'd0, bus.mem_ready}, 32'd1);
      chk("mid_rst_dready", {31'd0, bus.div_ready}, 32'd1);
      chk("mid_rst_busy_a", {31'd0, bus.q_busy_a}, 32'd0);
      chk("mid_rst_busy_b", {31'd0, bus.q_busy_b}, 32'd0);
      step();
      idle();
      reset_n = 1'b1;
      step();
      chk("rel_mready", {31'd0, bus.mem_ready}, 32'd1);
      chk("rel_dready", {31'd0, bus.div_ready}, 32'd1);

      for (int c = 0; c < 500; c++) begin
         randomize_inputs();
         step();
      end
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
